stage4_ex_mem_pipe_buf: RTL and testbench
=========================================

Name: stage4_ex_mem_pipe_buf

Overview:
- Parametrised elastic EX→MEM pipeline buffer for the rv32v 4-stage pipeline. Replaces the fixed single-entry EX/MEM register.
- Carries one scalar result, a destination register, and NUM_LANES vector lane words per entry in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Supports flush, and provides a forwarding lookup so EX can source pending scalar results.

Parameters:
- WORD_W, 32, scalar result / forwarding data width
- NUM_LANES, 4, vector lanes carried per entry
- LANE_W, 32, width of each vector lane word
- DEPTH, 2, buffer entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all entries (fence_i, CSR, mispredict)
- ex_valid  in  1  EX presents an entry
- ex_ready  out  1  buffer accepts an entry this cycle
- ex_reg_write  in  1  entry writes the scalar rd
- ex_rd  in  5  scalar destination register
- ex_wdata  in  WORD_W  scalar result
- ex_vmask  in  NUM_LANES  per-lane active mask
- ex_vdata  in  NUM_LANES*LANE_W  vector lane results, lane 0 in LSBs
- mem_valid  out  1  head entry valid
- mem_ready  in  1  MEM consumes the head entry
- mem_reg_write  out  1  head entry reg_write
- mem_rd  out  5  head entry rd
- mem_wdata  out  WORD_W  head entry scalar result
- mem_vmask  out  NUM_LANES  head entry lane mask
- mem_vdata  out  NUM_LANES*LANE_W  head entry lane data
- count  out  CNT_W  current occupancy
- fwd_rs  in  5  source register queried by EX
- fwd_hit  out  1  a buffered entry will write fwd_rs
- fwd_data  out  WORD_W  value from the youngest matching entry

Behaviour:
- Storage is a circular FIFO:
  - rd_ptr and wr_ptr are CNT_W bits and wrap modulo 2*DEPTH.
  - The low bits index storage.
  - count = wr_ptr − rd_ptr.
- Reset (nRST=0, asynchronous): pointers and count are 0, so mem_valid=0 and ex_ready=1. Storage contents are don't-care. Every mem_* payload output reads 0 because payload outputs are gated.
- ex_ready = (count < DEPTH). It depends on registered state only; there is no combinational path from mem_ready.
- Push when ex_valid && ex_ready. Pop when mem_valid && mem_ready.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- mem_valid = (count != 0).
- mem_* payload outputs show the head entry when mem_valid=1 and read 0 otherwise.
- Latency: an entry pushed in cycle N is visible at the MEM side in cycle N+1.
- Throughput is one entry per cycle with mem_ready held high.
- Full (count=DEPTH): ex_ready=0. A pop that cycle frees a slot, but the push is not accepted until the next cycle.
- Empty: mem_valid=0. mem_ready is ignored.
- flush=1:
  - At the next edge, rd_ptr := wr_ptr and count becomes 0.
  - Flush overrides any push and pop in the same cycle; the incoming entry is dropped.
  - ex_ready=1 in the following cycle.
- Forwarding (combinational):
  - Scan all valid entries from youngest to oldest.
  - fwd_hit=1 on the first entry with reg_write=1, rd==fwd_rs and fwd_rs≠0; fwd_data = that entry's wdata.
  - With no match, fwd_hit=0 and fwd_data=0.
  - The in-flight ex_* input is not included.
  - Forwarding is suppressed (fwd_hit=0) in any cycle where flush=1.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro: STAGE4_PIPE_BYPASS_EN.
- When defined, if count=0 and ex_valid && mem_ready && !flush:
  - The ex_* entry appears on mem_* combinationally in the same cycle with mem_valid=1.
  - The entry is consumed without being stored; pointers do not move.
  - Zero latency in this case.
- In the bypass cycle, fwd_hit ignores the bypassed entry.
- When undefined, latency is always exactly 1 cycle and there is no ex→mem combinational path.

Test Plan:
- Reset, then push rd=5, wdata=0xDEADBEEF, vmask=4'b1010 with mem_ready=1 → next cycle mem_valid=1, mem_rd=5, mem_wdata=0xDEADBEEF; count returns to 0 after the pop.
- DEPTH=2, mem_ready=0, push 3 entries back-to-back → first two accepted, count=2, ex_ready=0 on the 3rd. Raise mem_ready → entries pop in order and ex_ready=1 the cycle after the first pop.
- Buffer holds rd=7/0x11 (older) and rd=7/0x22 (younger); set fwd_rs=7 → fwd_hit=1, fwd_data=0x22. fwd_rs=0 with an rd=0 entry buffered → fwd_hit=0.
- count=2, assert flush together with a push and mem_ready=1 → next cycle count=0, mem_valid=0, ex_ready=1, nothing delivered.
- Drop nRST asynchronously mid-stream with count=1 → mem_valid=0 and count=0 immediately, before the next edge.
- STAGE4_PIPE_BYPASS_EN defined, empty buffer, ex_valid=1, mem_ready=1, wdata=0x1234 → mem_wdata=0x1234 in the same cycle and count stays 0. When undefined, the same stimulus delivers one cycle later.

Source files
------------

// File: rtl/stage4_ex_mem_pipe_buf_if.sv
// Handshake/payload bundle between EX and MEM for the rv32v elastic pipeline buffer.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface stage4_ex_mem_pipe_buf_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 32
);
  logic                        valid;
  logic                        ready;
  logic                        reg_write;
  logic [4:0]                  rd;
  logic [WORD_W-1:0]           wdata;
  logic [NUM_LANES-1:0]        vmask;
  logic [NUM_LANES*LANE_W-1:0] vdata;

  modport master (
    output valid,
    output reg_write,
    output rd,
    output wdata,
    output vmask,
    output vdata,
    input  ready
  );

  modport slave (
    input  valid,
    input  reg_write,
    input  rd,
    input  wdata,
    input  vmask,
    input  vdata,
    output ready
  );
endinterface

// File: rtl/stage4_ex_mem_pipe_buf.sv
// Elastic EX->MEM pipeline buffer: DEPTH-entry circular FIFO with flush and scalar forwarding.
// Optional macro STAGE4_PIPE_BYPASS_EN adds a zero-latency EX->MEM path when the buffer is empty.
module stage4_ex_mem_pipe_buf #(
  parameter int WORD_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         flush,
  stage4_ex_mem_pipe_buf_if.slave      ex,
  stage4_ex_mem_pipe_buf_if.master     mem,
  output logic [CNT_W-1:0]             count,
  input  logic [4:0]                   fwd_rs,
  output logic                         fwd_hit,
  output logic [WORD_W-1:0]            fwd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            wr_ptr;
  logic                        stored_valid;
  logic                        ex_ready_int;
  logic                        bypass;
  logic                        push;
  logic                        pop;
  logic [AW-1:0]               head_idx;
  logic [AW-1:0]               tail_idx;
  logic [AW-1:0]               scan_idx;

  logic                        reg_write_mem [DEPTH];
  logic [4:0]                  rd_mem        [DEPTH];
  logic [WORD_W-1:0]           wdata_mem     [DEPTH];
  logic [NUM_LANES-1:0]        vmask_mem     [DEPTH];
  logic [NUM_LANES*LANE_W-1:0] vdata_mem     [DEPTH];

  assign count        = wr_ptr - rd_ptr;
  assign stored_valid = (count != '0);
  assign ex_ready_int = (count < CNT_W'(DEPTH));
  assign ex.ready     = ex_ready_int;
  assign head_idx     = rd_ptr[AW-1:0];
  assign tail_idx     = wr_ptr[AW-1:0];

`ifdef STAGE4_PIPE_BYPASS_EN
  assign bypass = !stored_valid && ex.valid && mem.ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry is consumed directly by MEM and never occupies a slot.
  assign push = ex.valid && ex_ready_int && !bypass;
  assign pop  = stored_valid && mem.ready;

  // Flush wins over push and pop: the read pointer jumps to the write pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)  rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      reg_write_mem[tail_idx] <= ex.reg_write;
      rd_mem[tail_idx]        <= ex.rd;
      wdata_mem[tail_idx]     <= ex.wdata;
      vmask_mem[tail_idx]     <= ex.vmask;
      vdata_mem[tail_idx]     <= ex.vdata;
    end
  end

  // Payload is zeroed whenever nothing valid is presented to MEM.
  always_comb begin
    mem.valid     = 1'b0;
    mem.reg_write = 1'b0;
    mem.rd        = '0;
    mem.wdata     = '0;
    mem.vmask     = '0;
    mem.vdata     = '0;
    if (stored_valid) begin
      mem.valid     = 1'b1;
      mem.reg_write = reg_write_mem[head_idx];
      mem.rd        = rd_mem[head_idx];
      mem.wdata     = wdata_mem[head_idx];
      mem.vmask     = vmask_mem[head_idx];
      mem.vdata     = vdata_mem[head_idx];
    end
`ifdef STAGE4_PIPE_BYPASS_EN
    else if (bypass) begin
      mem.valid     = 1'b1;
      mem.reg_write = ex.reg_write;
      mem.rd        = ex.rd;
      mem.wdata     = ex.wdata;
      mem.vmask     = ex.vmask;
      mem.vdata     = ex.vdata;
    end
`endif
  end

  // Oldest-to-youngest scan; a later match overrides, so the youngest entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr[AW-1:0] + AW'(k);
      if ((CNT_W'(k) < count) && reg_write_mem[scan_idx] &&
          (rd_mem[scan_idx] == fwd_rs) && (fwd_rs != 5'd0)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_mem[scan_idx];
      end
    end
    if (flush) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

endmodule

// File: tb/tb_stage4_ex_mem_pipe_buf.sv
// Directed self-checking bench for stage4_ex_mem_pipe_buf (DEPTH=2, 4 lanes of 32 bits).
// Expectations for the same-cycle bypass case follow STAGE4_PIPE_BYPASS_EN.
module tb_stage4_ex_mem_pipe_buf;

  localparam int WORD_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 32;
  localparam int DEPTH     = 2;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              flush = 1'b0;
  logic [4:0]        fwd_rs = 5'd0;
  logic [CNT_W-1:0]  count;
  logic              fwd_hit;
  logic [WORD_W-1:0] fwd_data;

  int num_compared   = 0;
  int num_mismatched = 0;

  stage4_ex_mem_pipe_buf_if #(.WORD_W(WORD_W), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) ex_bus ();
  stage4_ex_mem_pipe_buf_if #(.WORD_W(WORD_W), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W)) mem_bus ();

  stage4_ex_mem_pipe_buf #(
    .WORD_W(WORD_W), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .flush(flush),
    .ex(ex_bus),
    .mem(mem_bus),
    .count(count),
    .fwd_rs(fwd_rs),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic reg_write, input logic [4:0] rd,
                                input logic [31:0] wdata, input logic [3:0] vmask,
                                input logic mem_ready, input logic flush_in);
    ex_bus.valid     = valid;
    ex_bus.reg_write = reg_write;
    ex_bus.rd        = rd;
    ex_bus.wdata     = wdata;
    ex_bus.vmask     = vmask;
    ex_bus.vdata     = {wdata + 32'd3, wdata + 32'd2, wdata + 32'd1, wdata};
    mem_bus.ready    = mem_ready;
    flush            = flush_in;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    check_output("rst_count", 128'(count), 128'd0);
    check_output("rst_mem_valid", 128'(mem_bus.valid), 128'd0);
    check_output("rst_ex_ready", 128'(ex_bus.ready), 128'd1);
    check_output("rst_mem_wdata", 128'(mem_bus.wdata), 128'd0);
    nRST = 1'b1;
    tick();

    // single entry through the buffer
    apply_stimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'b1010, 1'b1, 1'b0);
`ifdef STAGE4_PIPE_BYPASS_EN
    check_output("t1_byp_valid", 128'(mem_bus.valid), 128'd1);
    check_output("t1_byp_wdata", 128'(mem_bus.wdata), 128'hDEADBEEF);
    check_output("t1_byp_count", 128'(count), 128'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    check_output("t1_byp_after", 128'(mem_bus.valid), 128'd0);
`else
    check_output("t1_same_cycle_valid", 128'(mem_bus.valid), 128'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    check_output("t1_valid", 128'(mem_bus.valid), 128'd1);
    check_output("t1_rd", 128'(mem_bus.rd), 128'd5);
    check_output("t1_wdata", 128'(mem_bus.wdata), 128'hDEADBEEF);
    check_output("t1_vmask", 128'(mem_bus.vmask), 128'hA);
    check_output("t1_vdata", 128'(mem_bus.vdata), 128'hDEADBEF2_DEADBEF1_DEADBEF0_DEADBEEF);
    check_output("t1_count", 128'(count), 128'd1);
    tick();
`endif
    check_output("t1_count_end", 128'(count), 128'd0);
    check_output("t1_wdata_gated", 128'(mem_bus.wdata), 128'd0);

    // fill to full with MEM stalled, then drain
    apply_stimulus(1'b1, 1'b1, 5'd1, 32'hA1, 4'h1, 1'b0, 1'b0);
    check_output("t2_a_ready", 128'(ex_bus.ready), 128'd1);
    tick();
    apply_stimulus(1'b1, 1'b1, 5'd2, 32'hA2, 4'h2, 1'b0, 1'b0);
    check_output("t2_b_count", 128'(count), 128'd1);
    check_output("t2_b_ready", 128'(ex_bus.ready), 128'd1);
    tick();
    apply_stimulus(1'b1, 1'b1, 5'd3, 32'hA3, 4'h3, 1'b0, 1'b0);
    check_output("t2_c_count", 128'(count), 128'd2);
    check_output("t2_c_ready", 128'(ex_bus.ready), 128'd0);
    check_output("t2_c_head", 128'(mem_bus.wdata), 128'hA1);
    tick();
    apply_stimulus(1'b1, 1'b1, 5'd3, 32'hA3, 4'h3, 1'b1, 1'b0);
    check_output("t2_d_ready", 128'(ex_bus.ready), 128'd0);
    check_output("t2_d_head", 128'(mem_bus.wdata), 128'hA1);
    tick();
    check_output("t2_e_count", 128'(count), 128'd1);
    check_output("t2_e_ready", 128'(ex_bus.ready), 128'd1);
    check_output("t2_e_head", 128'(mem_bus.wdata), 128'hA2);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    check_output("t2_f_count", 128'(count), 128'd1);
    check_output("t2_f_head", 128'(mem_bus.wdata), 128'hA3);
    check_output("t2_f_rd", 128'(mem_bus.rd), 128'd3);
    tick();
    check_output("t2_g_valid", 128'(mem_bus.valid), 128'd0);

    // forwarding picks the youngest match
    apply_stimulus(1'b1, 1'b1, 5'd7, 32'h11, 4'h0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b1, 5'd7, 32'h22, 4'h0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    fwd_rs = 5'd7;
    #1;
    check_output("t3_hit7", 128'(fwd_hit), 128'd1);
    check_output("t3_data7", 128'(fwd_data), 128'h22);
    fwd_rs = 5'd3;
    #1;
    check_output("t3_miss_hit", 128'(fwd_hit), 128'd0);
    check_output("t3_miss_data", 128'(fwd_data), 128'd0);
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 1'b1, 5'd0, 32'h33, 4'h0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    fwd_rs = 5'd7;
    #1;
    check_output("t3_after_pop_data", 128'(fwd_data), 128'h22);
    fwd_rs = 5'd0;
    #1;
    check_output("t3_x0_hit", 128'(fwd_hit), 128'd0);
    check_output("t3_count", 128'(count), 128'd2);

    // flush with a simultaneous push and pop
    fwd_rs = 5'd7;
    apply_stimulus(1'b1, 1'b1, 5'd8, 32'h88, 4'h0, 1'b1, 1'b1);
    check_output("t4_fwd_suppressed", 128'(fwd_hit), 128'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    check_output("t4_count", 128'(count), 128'd0);
    check_output("t4_valid", 128'(mem_bus.valid), 128'd0);
    check_output("t4_ready", 128'(ex_bus.ready), 128'd1);
    tick();
    check_output("t4_nothing_late", 128'(mem_bus.valid), 128'd0);

    // reg_write=0 entries do not forward, then async reset mid-stream
    fwd_rs = 5'd9;
    apply_stimulus(1'b1, 1'b0, 5'd9, 32'h99, 4'h0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0);
    check_output("t5_count", 128'(count), 128'd1);
    check_output("t5_nowrite_hit", 128'(fwd_hit), 128'd0);
    check_output("t5_rd", 128'(mem_bus.rd), 128'd9);
    #2;
    nRST = 1'b0;
    #1;
    check_output("t5_async_count", 128'(count), 128'd0);
    check_output("t5_async_valid", 128'(mem_bus.valid), 128'd0);
    check_output("t5_async_rd", 128'(mem_bus.rd), 128'd0);
    tick();
    nRST = 1'b1;
    tick();

    // latency on an empty buffer with MEM ready
    fwd_rs = 5'd4;
    apply_stimulus(1'b1, 1'b1, 5'd4, 32'h1234, 4'hF, 1'b1, 1'b0);
`ifdef STAGE4_PIPE_BYPASS_EN
    check_output("t6_byp_valid", 128'(mem_bus.valid), 128'd1);
    check_output("t6_byp_wdata", 128'(mem_bus.wdata), 128'h1234);
    check_output("t6_byp_count", 128'(count), 128'd0);
    check_output("t6_byp_fwd", 128'(fwd_hit), 128'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    check_output("t6_byp_count_after", 128'(count), 128'd0);
    check_output("t6_byp_valid_after", 128'(mem_bus.valid), 128'd0);
`else
    check_output("t6_same_valid", 128'(mem_bus.valid), 128'd0);
    check_output("t6_same_wdata", 128'(mem_bus.wdata), 128'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 1'b0);
    check_output("t6_late_valid", 128'(mem_bus.valid), 128'd1);
    check_output("t6_late_wdata", 128'(mem_bus.wdata), 128'h1234);
    check_output("t6_late_count", 128'(count), 128'd1);
    check_output("t6_late_fwd", 128'(fwd_data), 128'h1234);
    tick();
    check_output("t6_drained", 128'(count), 128'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
